// File: rtl/mips_pkg.sv
// Shared types and constants for the fetch/decode pipeline slice.
package mips_pkg;

    localparam int unsigned WORD_WIDTH  = 32;
    localparam int unsigned INSTR_BYTES = 4;

    localparam logic [WORD_WIDTH-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
    localparam logic [WORD_WIDTH-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;

    // IF/ID pipeline register contents, also consumed by the decode stage.
    typedef struct packed {
        logic                  valid;
        logic [WORD_WIDTH-1:0] instruction;
        logic [WORD_WIDTH-1:0] pc;
        logic [WORD_WIDTH-1:0] pc_plus4;
    } if_id_t;

    // Empty slot: no real instruction, all address fields zero.
    function automatic if_id_t if_id_bubble(input logic [WORD_WIDTH-1:0] nop);
        if_id_t b;
        b.valid       = 1'b0;
        b.instruction = nop;
        b.pc          = '0;
        b.pc_plus4    = '0;
        return b;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if_id_register.sv
// IF/ID pipeline register with bubble > hold > load priority.
module if_id_register
    import mips_pkg::*;
#(
    parameter logic [WORD_WIDTH-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   bubble,
    input  logic   hold,
    input  if_id_t load_data,
    output if_id_t if_id
);

    if_id_t if_id_q;
    if_id_t if_id_d;

    // Next contents: bubble wins over hold, hold wins over a fresh load.
    always_comb begin
        if_id_d = if_id_q;
        if (bubble) begin
            if_id_d = if_id_bubble(NOP_INSTR);
        end else if (!hold) begin
            if_id_d = load_data;
        end
    end

    // Register with synchronous reset to an empty slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_q <= if_id_bubble(NOP_INSTR);
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign if_id = if_id_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, next-PC selection, memory word address and IF/ID capture.
module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 6,
    parameter logic [WORD_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [WORD_WIDTH-1:0] NOP_INSTR  = DEFAULT_NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  redirect_valid,
    input  logic [WORD_WIDTH-1:0] redirect_target,
    input  logic [WORD_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] instruction_address,
    output logic [WORD_WIDTH-1:0] pc,
    output logic                  if_id_valid,
    output logic [WORD_WIDTH-1:0] if_id_instruction,
    output logic [WORD_WIDTH-1:0] if_id_pc,
    output logic [WORD_WIDTH-1:0] if_id_pc_plus4
);

    localparam logic [WORD_WIDTH-1:0] ALIGN_MASK = ~WORD_WIDTH'(INSTR_BYTES - 1);
    localparam logic [WORD_WIDTH-1:0] PC_STEP    = WORD_WIDTH'(INSTR_BYTES);

    logic [WORD_WIDTH-1:0] pc_q;
    logic [WORD_WIDTH-1:0] pc_d;
    logic [WORD_WIDTH-1:0] pc_plus4;
    if_id_t                fetched;
    if_id_t                if_id;

    assign pc_plus4 = pc_q + PC_STEP;

    // Next PC: redirect (aligned) beats stall, otherwise sequential.
    always_comb begin
        pc_d = pc_plus4;
        if (redirect_valid) begin
            pc_d = redirect_target & ALIGN_MASK;
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    // PC register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Word address wraps naturally by slicing above the byte offset.
    assign instruction_address = pc_q[ADDR_WIDTH+1:2];
    assign pc                  = pc_q;

    always_comb begin
        fetched.valid       = 1'b1;
        fetched.instruction = instruction;
        fetched.pc          = pc_q;
        fetched.pc_plus4    = pc_plus4;
    end

    if_id_register #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk      (clk),
        .reset    (reset),
        .bubble   (redirect_valid | flush),
        .hold     (stall),
        .load_data(fetched),
        .if_id    (if_id)
    );

    assign if_id_valid       = if_id.valid;
    assign if_id_instruction = if_id.instruction;
    assign if_id_pc          = if_id.pc;
    assign if_id_pc_plus4    = if_id.pc_plus4;

endmodule
